// File: rtl/uart_pkg.sv
// UART shared definitions: FSM state encodings, parity selectors, default payload width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Encodings are shared with the RX FSM, so the values are pinned explicitly.
    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        START  = 3'b001,
        DATA   = 3'b010,
        PARITY = 3'b011,
        STOP   = 3'b100
    } uart_state_e;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit timer: counts 0..P-1 repeatedly, P latched on load (0 treated as 1).
// Latency: count restarts at 0 on the edge after load; last_cycle is combinational from the count.
// Backpressure: none; free-runs every cycle.
module uart_tx_bit_timer #(
    parameter int PRESC_WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [PRESC_WIDTH-1:0] presc,
    output logic                   last_cycle,
    output logic [PRESC_WIDTH-1:0] count
);

    logic [PRESC_WIDTH-1:0] count_q, count_d;
    logic [PRESC_WIDTH-1:0] presc_q, presc_d;
    logic [PRESC_WIDTH-1:0] presc_eff;

    // Effective period clamps a zero prescale to one cycle per bit; reload or wrap the count.
    always_comb begin
        presc_eff  = (presc_q == '0) ? PRESC_WIDTH'(1) : presc_q;
        last_cycle = (count_q == presc_eff - PRESC_WIDTH'(1));
        count_d    = last_cycle ? '0 : count_q + PRESC_WIDTH'(1);
        presc_d    = presc_q;
        if (load) begin
            count_d = '0;
            presc_d = presc;
        end
    end

    // Counter and latched period registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
            presc_q <= '0;
        end else begin
            count_q <= count_d;
            presc_q <= presc_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/uart_tx_fsm.sv
// UART transmitter: start, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
// Latency: TX_OUT falls and busy rises on the edge after the accept cycle.
// Backpressure: DATA_VALID accepted only in IDLE or the last STOP cycle; otherwise dropped.
module uart_tx_fsm
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH  = UART_DATA_WIDTH,
    parameter int PRESC_WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  P_DATA,
    input  logic                   DATA_VALID,
    input  logic                   PAR_EN,
    input  logic                   PAR_TYP,
    input  logic [PRESC_WIDTH-1:0] PRESCALE,
    output logic                   TX_OUT,
    output logic                   busy
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    uart_state_e            state_q, state_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic                   par_en_q, par_en_d;
    logic                   par_bit_q, par_bit_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [IDX_W-1:0]       idx_nxt;
    logic                   accept;
    logic                   last_cycle;
    logic [PRESC_WIDTH-1:0] bit_cnt_unused;

    // Timer is reloaded on every accept so each frame uses the PRESCALE captured with it.
    uart_tx_bit_timer #(
        .PRESC_WIDTH (PRESC_WIDTH)
    ) u_bit_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (accept),
        .presc      (PRESCALE),
        .last_cycle (last_cycle),
        .count      (bit_cnt_unused)
    );

    // Next-state, next-output and frame-capture logic; TX_OUT/busy are computed for the next state.
    always_comb begin
        accept    = DATA_VALID && ((state_q == IDLE) || ((state_q == STOP) && last_cycle));
        idx_nxt   = idx_q + IDX_W'(1);
        state_d   = state_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        idx_d     = idx_q;

        if (accept) begin
            data_d    = P_DATA;
            par_en_d  = PAR_EN;
            par_bit_d = (^P_DATA) ^ (PAR_TYP == PAR_ODD);
            idx_d     = '0;
        end

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (accept) begin
                    state_d = START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                if (last_cycle) begin
                    state_d = DATA;
                    idx_d   = '0;
                    tx_d    = data_q[0];
                end
            end
            DATA: begin
                if (last_cycle) begin
                    if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
                        if (par_en_q) begin
                            state_d = PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        idx_d = idx_nxt;
                        tx_d  = data_q[idx_nxt];
                    end
                end
            end
            PARITY: begin
                if (last_cycle) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                if (last_cycle) begin
                    if (accept) begin
                        state_d = START;
                        tx_d    = 1'b0;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // FSM state, registered outputs and latched frame contents.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            idx_q     <= idx_d;
        end
    end

    assign TX_OUT = tx_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Bench for uart_tx_fsm: table of single frames plus hand sequences for multi-cycle corners.
// Latency: outputs sampled on the falling edge, one START cycle per negedge after accept.
// Backpressure: DATA_VALID pulses inside and outside the accept window.
module tb_uart_tx_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_en;
    logic       par_typ;
    logic [5:0] prescale;
    logic       tx_out;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_fsm #(
        .DATA_WIDTH  (8),
        .PRESC_WIDTH (6)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .P_DATA     (p_data),
        .DATA_VALID (data_valid),
        .PAR_EN     (par_en),
        .PAR_TYP    (par_typ),
        .PRESCALE   (prescale),
        .TX_OUT     (tx_out),
        .busy       (busy)
    );

    // One frame: inputs at accept, inputs applied afterwards, expected serial bits (bit 0 first).
    typedef struct {
        logic [7:0]  data;
        logic        pe;
        logic        pt;
        logic [5:0]  presc;
        logic [5:0]  presc_after;
        logic [10:0] seq;
        int          nbits;
        int          p;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b required=%0b t=%0t", name, act, exp, $time);
        end
    endtask

    // Present one byte for a single accept edge.
    task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] ps);
        @(negedge clk);
        p_data     = d;
        par_en     = pe;
        par_typ    = pt;
        prescale   = ps;
        data_valid = 1'b1;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
    endtask

    // Check every cycle of nbits serial bits of p cycles each; optionally pulse DATA_VALID at one cycle.
    task automatic check_frame(input string tag, input logic [10:0] seq, input int nbits,
                               input int p, input int pulse_cyc);
        int cyc = 0;
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < p; c++) begin
                @(negedge clk);
                if (pulse_cyc >= 0 && cyc == pulse_cyc + 1) data_valid = 1'b0;
                chk($sformatf("%s_tx_bit%0d_cyc%0d", tag, b, c), tx_out, seq[b]);
                chk($sformatf("%s_busy_bit%0d_cyc%0d", tag, b, c), busy, 1'b1);
                if (cyc == pulse_cyc) begin
                    p_data     = 8'hFF;
                    data_valid = 1'b1;
                end
                cyc++;
            end
        end
    endtask

    task automatic check_idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk($sformatf("%s_idle_tx%0d", tag, i), tx_out, 1'b1);
            chk($sformatf("%s_idle_busy%0d", tag, i), busy, 1'b0);
        end
    endtask

    initial begin
        // data, pe, pt, presc, presc_after, seq = {parity?, stop/parity, data, start}, nbits, P
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 6'd4,  6'd7, 11'b0_1_10100101_0, 10, 4};
        vecs[1] = '{8'h07, 1'b1, 1'b0, 6'd8,  6'd7, 11'b1_1_00000111_0, 11, 8};
        vecs[2] = '{8'h07, 1'b1, 1'b1, 6'd8,  6'd7, 11'b1_0_00000111_0, 11, 8};
        vecs[3] = '{8'h3C, 1'b0, 1'b0, 6'd0,  6'd5, 11'b0_1_00111100_0, 10, 1};
        vecs[4] = '{8'h96, 1'b1, 1'b1, 6'd16, 6'd4, 11'b1_1_10010110_0, 11, 16};
        vecs[5] = '{8'hE1, 1'b1, 1'b0, 6'd1,  6'd3, 11'b1_0_11100001_0, 11, 1};

        rst        = 1'b0;
        p_data     = 8'h00;
        data_valid = 1'b0;
        par_en     = 1'b0;
        par_typ    = 1'b0;
        prescale   = 6'd4;

        // Reset state, both during and just after reset.
        repeat (3) @(negedge clk);
        chk("reset_tx", tx_out, 1'b1);
        chk("reset_busy", busy, 1'b0);
        rst = 1'b1;
        check_idle("post_reset", 2);

        // Table frames; inputs are scrambled right after accept and must not disturb the frame.
        for (int i = 0; i < 6; i++) begin
            send(vecs[i].data, vecs[i].pe, vecs[i].pt, vecs[i].presc);
            p_data   = ~vecs[i].data;
            par_en   = ~vecs[i].pe;
            par_typ  = ~vecs[i].pt;
            prescale = vecs[i].presc_after;
            check_frame($sformatf("vec%0d", i), vecs[i].seq, vecs[i].nbits, vecs[i].p, -1);
            check_idle($sformatf("vec%0d", i), 2);
        end

        // Back-to-back: DATA_VALID held high, second start right after first stop.
        @(negedge clk);
        p_data     = 8'h55;
        par_en     = 1'b0;
        par_typ    = 1'b0;
        prescale   = 6'd2;
        data_valid = 1'b1;
        @(posedge clk);
        #1;
        p_data = 8'hC3;
        check_frame("b2b_first", 11'b0_1_01010101_0, 10, 2, -1);
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        check_frame("b2b_second", 11'b0_1_11000011_0, 10, 2, -1);
        check_idle("b2b", 2);

        // DATA_VALID pulse mid-DATA is dropped: only 8'h00 goes out, then the line idles.
        send(8'h00, 1'b0, 1'b0, 6'd4);
        check_frame("ignore", 11'b0_1_00000000_0, 10, 4, 14);
        check_idle("ignore", 8);

        // Reset during the parity bit (odd parity of 8'h07 is 0, so the line is low then).
        send(8'h07, 1'b1, 1'b1, 6'd4);
        check_frame("rst_mid", 11'b0_0_00000111_0, 9, 4, -1);
        @(negedge clk);
        chk("rst_mid_parity_tx", tx_out, 1'b0);
        chk("rst_mid_parity_busy", busy, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_abort_tx", tx_out, 1'b1);
        chk("rst_mid_abort_busy", busy, 1'b0);
        rst = 1'b1;
        check_idle("rst_mid", 2);
        send(8'h5A, 1'b0, 1'b0, 6'd3);
        check_frame("rst_recover", 11'b0_1_01011010_0, 10, 3, -1);
        check_idle("rst_recover", 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
